// File: rtl/iob_uart_responder.sv
// iob_uart_responder: native-bus UART peripheral with an 8N1 transmitter,
// an 8N1 receiver and a single-byte receive buffer.
module iob_uart_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int DIV_RST = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              txd,
  input  logic              rxd
);

  localparam logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DIV       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(7);
  localparam logic [15:0]       DIV_INIT    = 16'(DIV_RST);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;

  tx_state_t         tx_state, tx_state_nx;
  rx_state_t         rx_state, rx_state_nx;
  logic [15:0]       div, div_eff;
  logic              tx_en, rx_en, tx_ready, rx_ready;
  logic [7:0]        rx_data;
  logic              accept, wr_acc, rd_acc, soft_abort, tx_load, rx_clr;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  logic              tx_go, tx_tick, tx_last;
  logic [15:0]       tx_cnt, tx_bdiv;
  logic [3:0]        tx_idx;
  logic [7:0]        tx_shift;

  logic              rx_s1, rx_s2, rx_prev, rx_fall, rx_tick, rx_half, rx_done;
  logic [15:0]       rx_cnt, rx_bdiv;
  logic [3:0]        rx_idx;
  logic [7:0]        rx_shift;

  // Divisors below 2 would make the half-bit wait zero cycles long.
  assign div_eff      = (div < 16'd2) ? 16'd2 : div;
  // A valid still high during the ready cycle is the tail of the previous request.
  assign accept       = valid & ~ready;
  assign wr_acc       = accept & wstrb;
  assign rd_acc       = accept & ~wstrb;
  assign soft_abort   = wr_acc && (address == A_SOFTRESET) && wdata[0];
  assign tx_load      = wr_acc && (address == A_TXDATA) && tx_en && tx_ready;
  assign rx_clr       = rd_acc && (address == A_RXDATA);
  assign unused_wdata = ^wdata[DATA_W-1:16];

  // Read data selection; write-only registers read back as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      A_TXREADY: rd_mux[0]   = tx_ready;
      A_RXREADY: rd_mux[0]   = rx_ready;
      A_RXDATA:  rd_mux[7:0] = rx_data;
      default:   ;
    endcase
  end

  // Bus handshake and control registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready <= 1'b0;
      rdata <= '0;
      div   <= DIV_INIT;
      tx_en <= 1'b0;
      rx_en <= 1'b0;
    end else begin
      ready <= accept;
      if (rd_acc) rdata <= rd_mux;
      if (wr_acc) begin
        case (address)
          A_SOFTRESET: if (wdata[0]) begin
            tx_en <= 1'b0;
            rx_en <= 1'b0;
          end
          A_DIV:   div   <= wdata[15:0];
          A_TXEN:  tx_en <= wdata[0];
          A_RXEN:  rx_en <= wdata[0];
          default: ;
        endcase
      end
    end
  end

  // Status flags and the receive buffer; a completing frame beats a read clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_ready <= 1'b1;
      rx_ready <= 1'b0;
      rx_data  <= 8'd0;
    end else begin
      if (soft_abort)   tx_ready <= 1'b1;
      else if (tx_load) tx_ready <= 1'b0;
      else if (tx_last) tx_ready <= 1'b1;
      if (soft_abort) rx_ready <= 1'b0;
      else if (rx_done) begin
        rx_ready <= 1'b1;
        rx_data  <= rx_shift;
      end else if (rx_clr) rx_ready <= 1'b0;
    end
  end

  assign tx_tick = (tx_cnt == tx_bdiv - 16'd1);
  // Flag the frame done one cycle early so tx_ready is up in the final STOP cycle.
  assign tx_last = (tx_state == TX_STOP) && (tx_cnt == tx_bdiv - 16'd2);

  // TX state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         tx_state <= TX_IDLE;
    else if (soft_abort) tx_state <= TX_IDLE;
    else                 tx_state <= tx_state_nx;
  end

  // TX next-state logic.
  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_go) tx_state_nx = TX_START;
      TX_START: if (tx_tick) tx_state_nx = TX_DATA;
      TX_DATA:  if (tx_tick && tx_idx == 4'd7) tx_state_nx = TX_STOP;
      TX_STOP:  if (tx_tick) tx_state_nx = TX_IDLE;
      default:  tx_state_nx = TX_IDLE;
    endcase
  end

  // TX bit timer and shifter; the divisor is re-latched at every bit boundary.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txd      <= 1'b1;
      tx_go    <= 1'b0;
      tx_cnt   <= 16'd0;
      tx_bdiv  <= DIV_INIT;
      tx_idx   <= 4'd0;
      tx_shift <= 8'd0;
    end else if (soft_abort) begin
      txd    <= 1'b1;
      tx_go  <= 1'b0;
      tx_cnt <= 16'd0;
      tx_idx <= 4'd0;
    end else begin
      if (tx_load) begin
        tx_go    <= 1'b1;
        tx_shift <= wdata[7:0];
      end
      case (tx_state)
        TX_IDLE: begin
          txd    <= 1'b1;
          tx_cnt <= 16'd0;
          tx_idx <= 4'd0;
          if (tx_go) begin
            txd     <= 1'b0;
            tx_go   <= 1'b0;
            tx_bdiv <= div_eff;
          end
        end
        default: begin
          if (tx_tick) begin
            tx_cnt  <= 16'd0;
            tx_bdiv <= div_eff;
            if (tx_state == TX_START) begin
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_idx   <= 4'd0;
            end else if (tx_state == TX_DATA) begin
              if (tx_idx == 4'd7) txd <= 1'b1;
              else begin
                txd      <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_idx   <= tx_idx + 4'd1;
              end
            end else txd <= 1'b1;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
      endcase
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = (rx_cnt == rx_bdiv - 16'd1);
  assign rx_half = (rx_cnt == (rx_bdiv >> 1) - 16'd1);
  assign rx_done = (rx_state == RX_STOP) && rx_tick && rx_s2;

  // RX state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         rx_state <= RX_IDLE;
    else if (soft_abort) rx_state <= RX_IDLE;
    else                 rx_state <= rx_state_nx;
  end

  // RX next-state logic; a bad stop bit parks in RX_BRK until the line idles.
  always_comb begin
    rx_state_nx = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_en && rx_fall) rx_state_nx = RX_START;
      RX_START: if (rx_half) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_idx == 4'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nx = rx_s2 ? RX_IDLE : RX_BRK;
      RX_BRK:   if (rx_s2) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  // RX synchronizer, sample timer and shifter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_cnt   <= 16'd0;
      rx_bdiv  <= DIV_INIT;
      rx_idx   <= 4'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_START: begin
          if (rx_half) begin
            rx_cnt  <= 16'd0;
            rx_bdiv <= div_eff;
            rx_idx  <= 4'd0;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= 16'd0;
            rx_bdiv  <= div_eff;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_idx != 4'd7) rx_idx <= rx_idx + 4'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        RX_STOP: rx_cnt <= rx_cnt + 16'd1;
        default: begin
          rx_cnt  <= 16'd0;
          rx_bdiv <= div_eff;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_uart_responder.sv
// Directed testbench for iob_uart_responder.
module tb_iob_uart_responder;

  logic        clk = 1'b0;
  logic        resetn, valid, wstrb, ready, txd, rxd, rxd_drv, loop_en;
  logic [2:0]  address;
  logic [31:0] wdata, rdata;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  iob_uart_responder #(.DATA_W(32), .ADDR_W(3), .DIV_RST(16)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .txd(txd), .rxd(rxd)
  );

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [2:0] a, input logic we, input logic [31:0] d,
                        output logic [31:0] q);
    int n = 0;
    valid = 1'b1; address = a; wstrb = we; wdata = d;
    do begin @(posedge clk); #1; n++; end while (ready !== 1'b1 && n < 20);
    chk("ready_seen", 32'(ready), 32'd1);
    q = rdata;
    valid = 1'b0; wstrb = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    access(a, 1'b1, d, q);
  endtask

  task automatic rdchk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] q;
    access(a, 1'b0, 32'd0, q);
    chk(tag, q, exp);
  endtask

  task automatic wait_txready();
    logic [31:0] q;
    int n = 0;
    do begin access(3'd5, 1'b0, 32'd0, q); n++; end while (q !== 32'd1 && n < 200);
    chk("txready_poll", q, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd_drv = f[k];
      step(div);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    int          t0;
    logic        saw_low;
    logic [9:0]  f;
    logic [7:0]  lb [3] = '{8'h00, 8'hFF, 8'h81};

    resetn = 1'b0; valid = 1'b0; address = 3'd0; wdata = 32'd0; wstrb = 1'b0;
    rxd_drv = 1'b1; loop_en = 1'b0;
    step(3);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_txd", 32'(txd), 32'd1);
    resetn = 1'b1;
    step(2);

    // handshake: ready exactly one cycle after valid, for one cycle
    valid = 1'b1; address = 3'd5; wstrb = 1'b0;
    step(1);
    chk("hs_ready_hi", 32'(ready), 32'd1);
    chk("hs_txready", rdata, 32'd1);
    valid = 1'b0;
    step(1);
    chk("hs_ready_lo", 32'(ready), 32'd0);
    chk("hs_rdata_hold", rdata, 32'd1);
    rdchk(3'd6, 32'd0, "rxready_rst");
    rdchk(3'd7, 32'd0, "rxdata_rst");
    rdchk(3'd0, 32'd0, "wo_read_zero");
    chk("idle_txd", 32'(txd), 32'd1);

    // TX 0x55 at div 16, with an ignored mid-frame write
    wr(3'd1, 32'd16);
    wr(3'd3, 32'd1);
    wr(3'd2, 32'h55);
    chk("tx_ready_cycle_txd", 32'(txd), 32'd1);
    t0 = cyc + 1;
    wait_cyc(t0);
    chk("tx_start_edge", 32'(txd), 32'd0);
    f = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      wait_cyc(t0 + 16 * k + 8);
      chk($sformatf("tx55_bit%0d", k), 32'(txd), 32'(f[k]));
      if (k == 2) begin
        wr(3'd2, 32'hAA);
        rdchk(3'd5, 32'd0, "txready_busy");
      end
    end
    wait_cyc(t0 + 158);
    rdchk(3'd5, 32'd0, "txready_before_last");
    rdchk(3'd5, 32'd1, "txready_after_frame");
    saw_low = 1'b0;
    repeat (60) begin step(1); if (txd !== 1'b1) saw_low = 1'b1; end
    chk("tx_aa_ignored", 32'(saw_low), 32'd0);

    // RX 0xA3 at div 16
    wr(3'd4, 32'd1);
    send_rx(8'hA3, 1'b1, 16);
    step(4);
    rdchk(3'd6, 32'd1, "rx_a3_ready");
    rdchk(3'd7, 32'h000000A3, "rx_a3_data");
    rdchk(3'd6, 32'd0, "rx_ready_cleared");

    // glitch, framing error, then a good frame
    rxd_drv = 1'b0;
    step(5);
    rxd_drv = 1'b1;
    step(30);
    rdchk(3'd6, 32'd0, "rx_glitch");
    send_rx(8'h5A, 1'b0, 16);
    step(10);
    rdchk(3'd6, 32'd0, "rx_framing");
    step(10);
    send_rx(8'h3C, 1'b1, 16);
    step(4);
    rdchk(3'd6, 32'd1, "rx_3c_ready");
    rdchk(3'd7, 32'h0000003C, "rx_3c_data");

    // loopback at div 4 with overrun
    wr(3'd1, 32'd4);
    loop_en = 1'b1;
    step(2);
    for (int i = 0; i < 3; i++) begin
      wait_txready();
      wr(3'd2, 32'(lb[i]));
    end
    wait_txready();
    step(20);
    rdchk(3'd6, 32'd1, "lb_rxready");
    rdchk(3'd7, 32'h00000081, "lb_overrun_data");

    // soft reset during data bit 3 of 0xF0 at div 12
    loop_en = 1'b0;
    step(2);
    wr(3'd1, 32'd12);
    wr(3'd2, 32'hF0);
    t0 = cyc + 1;
    wait_cyc(t0 + 52);
    chk("sr_bit3_low", 32'(txd), 32'd0);
    wr(3'd0, 32'd1);
    chk("sr_txd_high", 32'(txd), 32'd1);
    rdchk(3'd5, 32'd1, "sr_txready");
    wr(3'd2, 32'h01);
    saw_low = 1'b0;
    repeat (40) begin step(1); if (txd !== 1'b1) saw_low = 1'b1; end
    chk("sr_txen_cleared", 32'(saw_low), 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd2, 32'h01);
    t0 = cyc + 1;
    wait_cyc(t0);
    chk("sr2_start", 32'(txd), 32'd0);
    wait_cyc(t0 + 11);
    chk("sr2_start_end", 32'(txd), 32'd0);
    wait_cyc(t0 + 12);
    chk("sr_div_kept", 32'(txd), 32'd1);
    wait_txready();

    // asynchronous reset in the middle of a receive frame
    wr(3'd1, 32'd16);
    wr(3'd4, 32'd1);
    send_rx(8'h42, 1'b1, 16);
    step(4);
    rdchk(3'd6, 32'd1, "rx42_ready");
    rxd_drv = 1'b0;
    step(40);
    chk("rx_mid_state", 32'(dut.rx_state), 32'd2);
    #2 resetn = 1'b0;
    #1;
    chk("ar_rx_ready", 32'(dut.rx_ready), 32'd0);
    chk("ar_rx_state", 32'(dut.rx_state), 32'd0);
    chk("ar_tx_state", 32'(dut.tx_state), 32'd0);
    chk("ar_txd", 32'(txd), 32'd1);
    chk("ar_rdata", rdata, 32'd0);
    rxd_drv = 1'b1;
    step(3);
    resetn = 1'b1;
    step(2);
    rdchk(3'd6, 32'd0, "rxready_after_rst");
    rdchk(3'd7, 32'd0, "rxdata_after_rst");
    rdchk(3'd5, 32'd1, "txready_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
